// File: rtl/binary_morph_pkg.sv
// Shared constants, pipeline metadata type and helpers for the binary morphology blocks.
package binary_morph_pkg;

  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] BLACK = 8'h00;
  localparam int         LAT   = 3;

  // Sideband that travels alongside each pixel through the pipeline.
  typedef struct packed {
    logic en;
    logic hsync;
    logic vsync;
    logic border;
    logic over;
  } pixMeta_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_buffer_1b.sv
// One-bit wide, DEPTH-deep simple dual-port line memory with a registered read port.
// A read and a write to the same address in one cycle return the previously stored bit.
module line_buffer_1b #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic              wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic              rdData_o
);

  logic mem [0:DEPTH-1];
  logic rdData_q;

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
  end

  // Only the output register is reset; the storage array keeps whatever it held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData_q <= 1'b0;
    end else begin
      rdData_q <= mem[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/binary_erosion.sv
// 3x3 binary erosion of a 0x00/0xFF video stream; every output lags its input by 3 clocks.
// Define BORDER_PASS_EN to pass the input pixel through on border positions instead of black.
module binary_erosion
  import binary_morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_gary,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_en,
  output logic [7:0] out_gary,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_en
);

  localparam int            CW      = ADDR_W + 1;
  localparam logic [CW-1:0] COL_END = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_TWO = CW'(2);

  if (ADDR_W < clog2(IMG_WIDTH)) begin : gAddrCheck
    $error("binary_erosion: ADDR_W too narrow for IMG_WIDTH");
  end

  logic [CW-1:0]     col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic              enPrev_q;
  logic              pixIn;
  logic              inLine;
  logic              rowLow;
  logic [ADDR_W-1:0] rdAddr;
  pixMeta_t          meta0;
  logic              unusedGary;

  assign pixIn      = in_gary[7];
  assign unusedGary = ^in_gary[6:0];

  // Column one wider than the address so it can park at IMG_WIDTH for over-long lines.
  always_comb begin
    inLine = (col_q < COL_END);
    rowLow = in_vsync || (row_q < 2'd2);
    rdAddr = inLine ? col_q[ADDR_W-1:0] : '0;
    meta0  = '{en: in_en, hsync: in_hsync, vsync: in_vsync,
               border: rowLow || (col_q < COL_TWO) || !inLine, over: !inLine};
    col_d  = '0;
    if (in_en) begin
      col_d = inLine ? col_q + CW'(1) : col_q;
    end
    row_d = row_q;
    if (in_vsync) begin
      row_d = 2'd0;
    end else if (enPrev_q && !in_en && (row_q != 2'd2)) begin
      row_d = row_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      enPrev_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      enPrev_q <= in_en;
    end
  end

  logic              lb1Rd;
  logic              lb2Rd;
  logic              lb2WrEn_q;
  logic [ADDR_W-1:0] lb2WrAddr_q;

  line_buffer_1b #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) uLb1 (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (in_en && inLine),
    .wrAddr_i (rdAddr),
    .wrData_i (pixIn),
    .rdAddr_i (rdAddr),
    .rdData_o (lb1Rd)
  );

  // LB2 is fed one clock later from LB1's registered read of the same column.
  line_buffer_1b #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) uLb2 (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (lb2WrEn_q),
    .wrAddr_i (lb2WrAddr_q),
    .wrData_i (lb1Rd),
    .rdAddr_i (rdAddr),
    .rdData_o (lb2Rd)
  );

  logic     pix1_q;
  pixMeta_t meta1_q;
  pixMeta_t meta2_q;
  logic [2:0] winL_q, winM_q, winR_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1_q      <= 1'b0;
      meta1_q     <= '0;
      lb2WrEn_q   <= 1'b0;
      lb2WrAddr_q <= '0;
    end else begin
      pix1_q      <= pixIn;
      meta1_q     <= meta0;
      lb2WrEn_q   <= in_en && inLine;
      lb2WrAddr_q <= rdAddr;
    end
  end

  // Window columns hold {row r-2, row r-1, row r}; winR_q is the newest column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winL_q  <= '0;
      winM_q  <= '0;
      winR_q  <= '0;
      meta2_q <= '0;
    end else begin
      if (meta1_q.en) begin
        winL_q <= winM_q;
        winM_q <= winR_q;
        winR_q <= {lb2Rd, lb1Rd, pix1_q};
      end
      meta2_q <= meta1_q;
    end
  end

  logic [7:0] gary_d;

  always_comb begin
    gary_d = BLACK;
    if (meta2_q.en) begin
      if (!meta2_q.border) begin
        gary_d = (&{winL_q, winM_q, winR_q}) ? WHITE : BLACK;
      end
`ifdef BORDER_PASS_EN
      else if (!meta2_q.over) begin
        gary_d = winR_q[0] ? WHITE : BLACK;
      end
`else
      else begin
        gary_d = BLACK;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gary  <= BLACK;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_en    <= 1'b0;
    end else begin
      out_gary  <= gary_d;
      out_hsync <= meta2_q.hsync;
      out_vsync <= meta2_q.vsync;
      out_en    <= meta2_q.en;
    end
  end

endmodule
